phi_clock_gen: RTL and testbench

Generates a slow, CPU-style two-phase clock (`dout`) from the fast system clock with programmable high and low phase lengths. Produces one-cycle advance strobes ahead of each edge, so fast-domain logic can act on an edge without sampling the clock back through an edge detector. Supports a stop request that stretches the low phase indefinitely. Sits in the clock-control path, driving the host-side phase clock and its qualifying strobes.

---
 rtl/phi_clock_gen.sv | 110 +++++++++++
 tb/tb_phi_clock_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/phi_clock_gen.sv
// phi_clock_gen: two-phase slow clock generated from the fast system clock.
// The high and low phase lengths are programmable. rise_pre and fall_pre are
// one-cycle strobes that fire in the cycle before each dout edge. stop_req
// holds dout low at the end of the current low phase until it is released.
module phi_clock_gen #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hi_len,
    input  logic [CNT_W-1:0] lo_len,
    input  logic             stop_req,
    output logic             dout,
    output logic             rise_pre,
    output logic             fall_pre,
    output logic             stopped
);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_HIGH = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dout_nxt, stopped_nxt;
    logic [CNT_W-1:0] hi_eff, lo_eff;
    logic             cnt_zero;

    // A zero phase length is clamped to one cycle so the clock never stalls.
    assign hi_eff   = (hi_len == '0) ? CNT_W'(1) : hi_len;
    assign lo_eff   = (lo_len == '0) ? CNT_W'(1) : lo_len;
    assign cnt_zero = (cnt == '0);

    // The strobes are decoded from the current state, so each one leads the
    // registered dout edge by exactly one clk cycle.
    assign rise_pre = ((state == ST_LOW) && cnt_zero && !stop_req) ||
                      ((state == ST_STOP) && !stop_req);
    assign fall_pre = (state == ST_HIGH) && cnt_zero;

    // State, counter and output registers. Reset forces dout low immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_LOW;
            cnt     <= '0;
            dout    <= 1'b0;
            stopped <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dout    <= dout_nxt;
            stopped <= stopped_nxt;
        end
    end

    // Next-state logic. Phase lengths are sampled only at the edge that starts
    // a phase, so a length change in the middle of a phase waits for the next
    // phase start.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dout_nxt    = dout;
        stopped_nxt = stopped;
        case (state)
            ST_LOW: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (stop_req) begin
                    state_nxt   = ST_STOP;
                    dout_nxt    = 1'b0;
                    stopped_nxt = 1'b1;
                end else begin
                    state_nxt = ST_HIGH;
                    dout_nxt  = 1'b1;
                    cnt_nxt   = hi_eff - CNT_W'(1);
                end
            end
            ST_HIGH: begin
                // stop_req is ignored in this state: a high phase is never cut
                // short or stretched.
                if (!cnt_zero) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_LOW;
                    dout_nxt  = 1'b0;
                    cnt_nxt   = lo_eff - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (!stop_req) begin
                    state_nxt   = ST_HIGH;
                    dout_nxt    = 1'b1;
                    cnt_nxt     = hi_eff - CNT_W'(1);
                    stopped_nxt = 1'b0;
                end else begin
                    dout_nxt    = 1'b0;
                    stopped_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_LOW;
                cnt_nxt     = '0;
                dout_nxt    = 1'b0;
                stopped_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_phi_clock_gen.sv
// Directed bench for phi_clock_gen. Inputs change 1 ns after each rising edge,
// and outputs are sampled on the falling edge. Cycle 0 is the first cycle after
// reset is released. Expected waveforms are bit vectors indexed by cycle.
module tb_phi_clock_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] hi_len = 4'd1;
    logic [3:0] lo_len = 4'd1;
    logic       stop_req = 1'b0;
    logic       dout, rise_pre, fall_pre, stopped;

    int checks = 0;
    int errors = 0;

    phi_clock_gen #(.CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .hi_len   (hi_len),
        .lo_len   (lo_len),
        .stop_req (stop_req),
        .dout     (dout),
        .rise_pre (rise_pre),
        .fall_pre (fall_pre),
        .stopped  (stopped)
    );

    // Fast clock with a 10 ns period.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one rising edge. Release happens at the start of cycle 0.
    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        hi_len = 4'd1; lo_len = 4'd1; stop_req = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dout, rise_pre, fall_pre, stopped} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold_stop: got %b expected 0000", {dout, rise_pre, fall_pre, stopped});
        end
        stop_req = 1'b0;
        #1;
        checks++;
        if ({dout, rise_pre, fall_pre, stopped} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 0100", {dout, rise_pre, fall_pre, stopped});
        end
        // Drive the DUT into STOP, then check that reset clears stopped at once.
        stop_req = 1'b1;
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({dout, rise_pre, fall_pre, stopped} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_enter_stop: got %b expected 0001", {dout, rise_pre, fall_pre, stopped});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({dout, stopped} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async_clear: got %b expected 00", {dout, stopped});
        end
        stop_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [0:16] ed, er, ef;
        ed = 17'b0_1111_0000_1111_0000;
        er = 17'b1_0000_0001_0000_0001;
        ef = 17'b0_0001_0000_0001_0000;
        hi_len = 4'd4; lo_len = 4'd4; stop_req = 1'b0;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            checks++;
            if ({dout, rise_pre, fall_pre, stopped} !== {ed[i], er[i], ef[i], 1'b0}) begin
                errors++;
                $display("FAIL basic cyc %0d: got %b expected %b", i,
                         {dout, rise_pre, fall_pre, stopped}, {ed[i], er[i], ef[i], 1'b0});
            end
            step();
        end
    endtask

    task automatic test_len_change();
        logic [0:15] ed, er, ef;
        ed = 16'b0111_0000_0111_0011;
        er = 16'b1000_0000_1000_0100;
        ef = 16'b0001_0000_0001_0000;
        hi_len = 4'd3; lo_len = 4'd5; stop_req = 1'b0;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) lo_len = 4'd2;
            @(negedge clk);
            checks++;
            if ({dout, rise_pre, fall_pre, stopped} !== {ed[i], er[i], ef[i], 1'b0}) begin
                errors++;
                $display("FAIL len_change cyc %0d: got %b expected %b", i,
                         {dout, rise_pre, fall_pre, stopped}, {ed[i], er[i], ef[i], 1'b0});
            end
            step();
        end
    endtask

    task automatic test_min_len();
        logic [0:7] ed, er, ef;
        ed = 8'b0101_0101;
        er = 8'b1010_1010;
        ef = 8'b0101_0101;
        hi_len = 4'd0; lo_len = 4'd0; stop_req = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({dout, rise_pre, fall_pre, stopped} !== {ed[i], er[i], ef[i], 1'b0}) begin
                errors++;
                $display("FAIL min_len cyc %0d: got %b expected %b", i,
                         {dout, rise_pre, fall_pre, stopped}, {ed[i], er[i], ef[i], 1'b0});
            end
            step();
        end
    endtask

    task automatic test_stop();
        logic [0:16] ed, er, ef, es, sr;
        ed = 17'b0_111_000000000_111_0;
        er = 17'b1_00000000000_1_0000;
        ef = 17'b000_1_00000000000_1_0;
        es = 17'b000000_1111111_0000;
        sr = 17'b00_1111111111_00000;
        hi_len = 4'd3; lo_len = 4'd2; stop_req = 1'b0;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            stop_req = sr[i];
            @(negedge clk);
            checks++;
            if ({dout, rise_pre, fall_pre, stopped} !== {ed[i], er[i], ef[i], es[i]}) begin
                errors++;
                $display("FAIL stop cyc %0d: got %b expected %b", i,
                         {dout, rise_pre, fall_pre, stopped}, {ed[i], er[i], ef[i], es[i]});
            end
            step();
        end
        stop_req = 1'b0;
    endtask

    task automatic test_stop_pulse();
        logic [0:9] ed, er, ef, sr;
        ed = 10'b0110000110;
        er = 10'b1000001000;
        ef = 10'b0010000010;
        sr = 10'b0000100100;
        hi_len = 4'd2; lo_len = 4'd4; stop_req = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            stop_req = sr[i];
            @(negedge clk);
            checks++;
            if ({dout, rise_pre, fall_pre, stopped} !== {ed[i], er[i], ef[i], 1'b0}) begin
                errors++;
                $display("FAIL stop_pulse cyc %0d: got %b expected %b", i,
                         {dout, rise_pre, fall_pre, stopped}, {ed[i], er[i], ef[i], 1'b0});
            end
            step();
        end
        stop_req = 1'b0;
    endtask

    task automatic test_reset_mid_high();
        logic [0:2] pd, pr;
        logic [0:7] ed, er, ef;
        pd = 3'b011;
        pr = 3'b100;
        ed = 8'b0111_1110;
        er = 8'b1000_0000;
        ef = 8'b0000_0010;
        hi_len = 4'd6; lo_len = 4'd3; stop_req = 1'b0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dout, rise_pre, fall_pre} !== {pd[i], pr[i], 1'b0}) begin
                errors++;
                $display("FAIL rst_mid_pre cyc %0d: got %b expected %b", i,
                         {dout, rise_pre, fall_pre}, {pd[i], pr[i], 1'b0});
            end
            step();
        end
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dout, rise_pre, fall_pre, stopped} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid_async: got %b expected 0100", {dout, rise_pre, fall_pre, stopped});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({dout, rise_pre, fall_pre, stopped} !== {ed[i], er[i], ef[i], 1'b0}) begin
                errors++;
                $display("FAIL rst_mid_post cyc %0d: got %b expected %b", i,
                         {dout, rise_pre, fall_pre, stopped}, {ed[i], er[i], ef[i], 1'b0});
            end
            step();
        end
    endtask

    initial begin
        step();
        test_reset();
        test_basic();
        test_len_change();
        test_min_len();
        test_stop();
        test_stop_pulse();
        test_reset_mid_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
